// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   UART receive front end. The serial line is synchronised, 8N1 frames are
//   deframed by an oversampling state machine, and received characters are
//   buffered in a small FIFO drained by a valid/ready consumer. Framing
//   errors and FIFO overruns are reported as sticky flags.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          synchronous, active-high reset
//   rx_i         asynchronous serial line, idle high
//   data_o       FIFO head character (combinational from storage)
//   valid_o      FIFO non-empty
//   ready_i      consumer pops the head when valid_o & ready_i
//   count_o      current FIFO occupancy
//   busy_o       receiver is mid-frame
//   frame_err_o  sticky: stop bit sampled low
//   overrun_o    sticky: character arrived with the FIFO full
//   clear_i      one-cycle pulse clearing both sticky flags
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int BAUD_RATE   = 115200,
    parameter int CLOCK_SPEED = 100000000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_i,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          busy_o,
    output logic                          frame_err_o,
    output logic                          overrun_o,
    input  logic                          clear_i
);

    localparam int CLKS_PER_BIT = CLOCK_SPEED / BAUD_RATE;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int CW           = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Receiver registers
    logic                  r_sync1;
    logic                  r_rx_s;
    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;

    // FIFO registers
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_frame_err;
    logic                  r_overrun;

    // Control wires
    state_t                w_state_next;
    logic                  w_cnt_clr;
    logic                  w_shift_en;
    logic                  w_push_req;
    logic                  w_frame_set;
    logic                  w_half_hit;
    logic                  w_bit_hit;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_overrun_set;

    // Two-flop synchronizer; resets to the idle (high) line level so a reset
    // never looks like a start bit.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_rx_s  <= r_sync1;
        end
    end

    assign w_half_hit = (r_cnt == CNT_W'(HALF - 1));
    assign w_bit_hit  = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal gets a default before the case so no path through
    // the block leaves it unassigned, which would infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_shift_en   = 1'b0;
        w_push_req   = 1'b0;
        w_frame_set  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_clr = 1'b1;
                if (!r_rx_s) begin
                    w_state_next = START;
                end
            end
            START: begin
                // Re-check the line mid start bit to reject glitches.
                if (w_half_hit) begin
                    w_cnt_clr    = 1'b1;
                    w_state_next = r_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_bit_hit) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
                        w_state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (w_bit_hit) begin
                    w_cnt_clr    = 1'b1;
                    w_push_req   = r_rx_s;
                    w_frame_set  = !r_rx_s;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Baud counter, bit index and LSB-first shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
            if (r_state != DATA) begin
                r_bit_idx <= '0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
            if (w_shift_en) begin
                r_shift <= {r_rx_s, r_shift[DATA_WIDTH-1:1]};
            end
        end
    end

    // FIFO control. A pop frees a slot in the same cycle, so a push into a
    // full FIFO still lands when the consumer pops alongside it.
    assign w_full        = (r_count == CW'(FIFO_DEPTH));
    assign w_pop         = ready_i && (r_count != '0);
    assign w_push        = w_push_req && (!w_full || w_pop);
    assign w_overrun_set = w_push_req && w_full && !w_pop;

    // NOTE: only entry 0 is reset, which is all that is needed for data_o to
    // read zero out of reset; the rest of the array stays plain storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle as clear_i wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_frame_set) begin
                r_frame_err <= 1'b1;
            end else if (clear_i) begin
                r_frame_err <= 1'b0;
            end
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (clear_i) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign data_o      = r_mem[r_rd_ptr];
    assign valid_o     = (r_count != '0);
    assign count_o     = r_count;
    assign busy_o      = (r_state != IDLE);
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo at 16 clocks per bit. Drives 8N1 frames
//   on rx_i and checks the FIFO stream and status flags against hand-computed
//   values.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic [3:0] count_o;
    logic       busy_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       clear_i;

    int n_tests;
    int n_fail;

    uart_rx_fifo #(
        .DATA_WIDTH  (8),
        .BAUD_RATE   (100),
        .CLOCK_SPEED (1600),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .count_o     (count_o),
        .busy_o      (busy_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .clear_i     (clear_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge. Drives start, 8 data bits LSB first,
    // then the stop level held for stop_cycles clocks.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_cycles);
        rx_i = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            cycles(CPB);
        end
        rx_i = stop;
        cycles(stop_cycles);
    endtask

    task automatic pop_one();
        ready_i = 1'b1;
        cycles(1);
        ready_i = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        cycles(1);
        clear_i = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        rx_i    = 1'b1;
        ready_i = 1'b0;
        clear_i = 1'b0;
        cycles(3);
        rst = 1'b0;

        // Reset state
        check("rst_valid", valid_o, 0);
        check("rst_count", count_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ferr", frame_err_o, 0);
        check("rst_ovr", overrun_o, 0);
        check("rst_data", data_o, 0);
        cycles(4);

        // 0xA5: stop sample lands 11 clocks into the stop bit
        send_frame(8'hA5, 1'b1, 10);
        check("a5_pre_valid", valid_o, 0);
        check("a5_pre_busy", busy_o, 1);
        cycles(1);
        check("a5_valid", valid_o, 1);
        check("a5_data", data_o, 8'hA5);
        check("a5_count", count_o, 1);
        check("a5_busy", busy_o, 0);
        check("a5_ferr", frame_err_o, 0);
        check("a5_ovr", overrun_o, 0);
        cycles(5);
        pop_one();
        check("a5_popped", count_o, 0);

        // False start: 5-clock low pulse
        rx_i = 1'b0;
        cycles(5);
        check("fs_busy_mid", busy_o, 1);
        rx_i = 1'b1;
        cycles(20);
        check("fs_busy", busy_o, 0);
        check("fs_count", count_o, 0);
        check("fs_ferr", frame_err_o, 0);
        check("fs_ovr", overrun_o, 0);

        // Framing error on 0x3C, then clear
        send_frame(8'h3C, 1'b0, CPB);
        rx_i = 1'b1;
        cycles(20);
        check("fe_count", count_o, 0);
        check("fe_flag", frame_err_o, 1);
        check("fe_busy", busy_o, 0);
        pulse_clear();
        check("fe_cleared", frame_err_o, 0);

        // Nine characters into an 8-deep FIFO
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b1, CPB);
            if (i == 8) begin
                check("ov_count8", count_o, 8);
                check("ov_flag_pre", overrun_o, 0);
            end
        end
        check("ov_count", count_o, 8);
        check("ov_flag", overrun_o, 1);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("ov_pop%0d", i), data_o, i);
            pop_one();
        end
        check("ov_empty", count_o, 0);
        check("ov_valid", valid_o, 0);
        pulse_clear();
        check("ov_cleared", overrun_o, 0);

        // Full FIFO: push and pop in the same cycle
        for (int i = 0; i < 8; i++) begin
            send_frame(8'h11 + 8'(i), 1'b1, CPB);
        end
        check("pp_full", count_o, 8);
        send_frame(8'h09, 1'b1, 10);
        ready_i = 1'b1;
        cycles(1);
        ready_i = 1'b0;
        check("pp_count", count_o, 8);
        check("pp_ovr", overrun_o, 0);
        cycles(5);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pp_pop%0d", i), data_o, (i < 7) ? (32'h12 + i) : 32'h09);
            pop_one();
        end
        check("pp_empty", count_o, 0);

        // Leave a byte queued and a framing error whose set coincides with clear
        send_frame(8'h77, 1'b1, CPB);
        check("sw_queued", data_o, 8'h77);
        send_frame(8'h3C, 1'b0, 10);
        clear_i = 1'b1;
        cycles(1);
        clear_i = 1'b0;
        check("sw_set_wins", frame_err_o, 1);
        rx_i = 1'b1;
        cycles(20);

        // Reset during bit 4 of 0xF0 (line high from bit 4 on)
        rx_i = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 4; i++) begin
            rx_i = 1'b0;
            cycles(CPB);
        end
        rx_i = 1'b1;
        cycles(8);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("mr_valid", valid_o, 0);
        check("mr_count", count_o, 0);
        check("mr_busy", busy_o, 0);
        check("mr_ferr", frame_err_o, 0);
        check("mr_ovr", overrun_o, 0);
        check("mr_data", data_o, 0);
        cycles(4 * CPB);
        check("mr_idle", busy_o, 0);

        send_frame(8'h5A, 1'b1, CPB);
        check("mr_5a_data", data_o, 8'h5A);
        check("mr_5a_count", count_o, 1);
        check("mr_5a_ferr", frame_err_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
